// File: rtl/tt_um_weight_loader_pkg.sv
// Shared ternary-weight types: loader FSM states, 2-bit weight codes
// and the layout of the param byte.
package tt_ternary_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        CHECK,
        COMMIT
    } state_t;

    localparam logic [1:0] TERN_ZERO    = 2'b00;
    localparam logic [1:0] TERN_POS     = 2'b01;
    localparam logic [1:0] TERN_ILLEGAL = 2'b10;
    localparam logic [1:0] TERN_NEG     = 2'b11;

    localparam int WEIGHTS_PER_BYTE = 4;
    localparam int PARAM_ROWS_MSB   = 6;
    localparam int PARAM_ROWS_LSB   = 3;

endpackage

// File: rtl/tt_um_weight_loader_if.sv
// Byte-stream valid/ready handshake into the weight loader.
interface tt_um_weight_loader_if;

    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);

endinterface

// File: rtl/tt_um_weight_loader_byte_check.sv
// Flags any illegal ternary code (2'b10) among the four fields of a byte.
module tt_ternary_byte_check
    import tt_ternary_pkg::*;
(
    input  logic [7:0] data,
    output logic       illegal
);

    always_comb begin
        illegal = 1'b0;
        for (int i = 0; i < WEIGHTS_PER_BYTE; i++) begin
            if (data[2*i +: 2] == TERN_ILLEGAL) illegal = 1'b1;
        end
    end

endmodule

// File: rtl/tt_um_weight_loader.sv
// Loads param + packed ternary weights into a shadow image, commits atomically.
// Define WEIGHT_CHECKSUM_EN to require a trailing XOR checksum byte.
module tt_um_weight_loader
    import tt_ternary_pkg::*;
#(
    parameter int MAX_IN_LEN  = 16,
    parameter int MAX_OUT_LEN = 8
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              ena,
    tt_um_weight_loader_if.slave              bus,
    output logic [6:0]                        uo_param,
    output logic [2*MAX_IN_LEN*MAX_OUT_LEN-1:0] uo_weights,
    output logic                              uo_load_done,
    output logic                              uo_busy,
    output logic                              uo_err
);

    localparam int WW        = 2 * MAX_IN_LEN * MAX_OUT_LEN;
    localparam int NBYTES    = MAX_IN_LEN * MAX_OUT_LEN / WEIGHTS_PER_BYTE;
    localparam int ROW_BYTES = MAX_OUT_LEN / WEIGHTS_PER_BYTE;
    localparam int IW        = $clog2(NBYTES);
    localparam int CW        = IW + 1;

    state_t          state, state_nxt;
    logic [CW-1:0]   byte_cnt, n_bytes;
    logic [6:0]      param;
    logic [WW-1:0]   shadow;
    logic            rdy, take, last, illegal;

    tt_ternary_byte_check u_check (
        .data    (bus.in_data),
        .illegal (illegal)
    );

    assign rdy          = ena && (state != COMMIT);
    assign take         = rdy && bus.in_valid;
    assign bus.in_ready = rdy;
    assign uo_busy      = (state != IDLE);

    assign n_bytes = (CW'(param[PARAM_ROWS_MSB:PARAM_ROWS_LSB]) + CW'(1))
                   * CW'(ROW_BYTES);
    assign last    = (byte_cnt == n_bytes - CW'(1));

`ifdef WEIGHT_CHECKSUM_EN
    logic [7:0] csum;
    logic       csum_ok;
    assign csum_ok = (csum == bus.in_data);
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:   if (take) state_nxt = LOAD;
            LOAD: begin
                if (!ena) state_nxt = IDLE;
`ifdef WEIGHT_CHECKSUM_EN
                else if (take && last) state_nxt = CHECK;
`else
                else if (take && last) state_nxt = COMMIT;
`endif
            end
            CHECK: begin
`ifdef WEIGHT_CHECKSUM_EN
                if (!ena)      state_nxt = IDLE;
                else if (take) state_nxt = csum_ok ? COMMIT : IDLE;
`else
                state_nxt = IDLE;
`endif
            end
            COMMIT: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            byte_cnt     <= '0;
            param        <= '0;
            shadow       <= '0;
            uo_param     <= '0;
            uo_weights   <= '0;
            uo_load_done <= 1'b0;
            uo_err       <= 1'b0;
`ifdef WEIGHT_CHECKSUM_EN
            csum         <= '0;
`endif
        end else begin
            uo_load_done <= 1'b0;
            case (state)
                IDLE: if (take) begin
                    param    <= bus.in_data[6:0];
                    shadow   <= '0;
                    byte_cnt <= '0;
                    uo_err   <= 1'b0;
`ifdef WEIGHT_CHECKSUM_EN
                    csum     <= bus.in_data;
`endif
                end
                LOAD: if (take) begin
                    // illegal codes are kept as-is; only the flag records them
                    shadow[{byte_cnt[IW-1:0], 3'b000} +: 8] <= bus.in_data;
                    byte_cnt <= byte_cnt + CW'(1);
                    if (illegal) uo_err <= 1'b1;
`ifdef WEIGHT_CHECKSUM_EN
                    csum     <= csum ^ bus.in_data;
`endif
                end
                CHECK: begin
`ifdef WEIGHT_CHECKSUM_EN
                    if (take && !csum_ok) uo_err <= 1'b1;
`endif
                end
                COMMIT: begin
                    uo_weights   <= shadow;
                    uo_param     <= param;
                    uo_load_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_tt_um_weight_loader.sv
// Randomized scoreboard bench for tt_um_weight_loader.
module tb_tt_um_weight_loader;

    localparam int W = 256;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         ena = 1'b0;
    logic [6:0]   uo_param;
    logic [W-1:0] uo_weights;
    logic         uo_load_done, uo_busy, uo_err;

    tt_um_weight_loader_if bus ();

    tt_um_weight_loader #(.MAX_IN_LEN(16), .MAX_OUT_LEN(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ena          (ena),
        .bus          (bus),
        .uo_param     (uo_param),
        .uo_weights   (uo_weights),
        .uo_load_done (uo_load_done),
        .uo_busy      (uo_busy),
        .uo_err       (uo_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0]   param;
        logic [W-1:0] img;
    } exp_t;

    exp_t         sb[$];
    exp_t         mon_e;
    logic [6:0]   cur_param = '0;
    logic [W-1:0] cur_img = '0;
    int           passed = 0;
    int           total = 0;

    task automatic check(input string name, input logic [W-1:0] act,
                         input logic [W-1:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // reference image: weight gi is field gi%4 of stream byte gi/4
    function automatic logic [W-1:0] pack(input logic [7:0] b[$]);
        logic [W-1:0] img = '0;
        for (int gi = 0; gi < b.size() * 4; gi++)
            img[2*gi +: 2] = 2'((b[gi/4] >> (2 * (gi % 4))) & 8'h03);
        return img;
    endfunction

    function automatic bit has_illegal(input logic [7:0] b[$]);
        for (int gi = 0; gi < b.size() * 4; gi++)
            if (((b[gi/4] >> (2 * (gi % 4))) & 8'h03) == 8'h02) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [7:0] legal_byte();
        logic [7:0] r = '0;
        for (int j = 0; j < 4; j++) begin
            int c = $urandom_range(0, 2);
            r[2*j +: 2] = (c == 2) ? 2'b11 : 2'(c);
        end
        return r;
    endfunction

    always @(negedge clk) begin
        if (rst_n && uo_load_done) begin
            if (sb.size() == 0) begin
                total++;
                $display("FAIL unexpected_done: got done=1 expected done=0");
            end else begin
                mon_e = sb.pop_front();
                check("commit_param", W'(uo_param), W'(mon_e.param));
                check("commit_weights", uo_weights, mon_e.img);
                cur_param = mon_e.param;
                cur_img   = mon_e.img;
            end
        end
    end

    task automatic send(input logic [7:0] b);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        while (!bus.in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            total++;
            $display("FAIL ready_timeout: got in_ready=0 expected 1");
        end
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic load(input logic [6:0] prm, input logic [7:0] wb[$],
                        input bit gap, input bit bad_sum);
        logic [7:0] pbyte = {1'($urandom), prm};
        logic [7:0] sum = pbyte;
        bit         ill = has_illegal(wb);
        bit         commit = 1'b1;
        exp_t       e;
        e.param = prm;
        e.img   = pack(wb);
        foreach (wb[i]) sum ^= wb[i];
        send(pbyte);
        check("err_clear", W'(uo_err), '0);
        for (int i = 0; i < wb.size(); i++) begin
            if (gap) @(negedge clk);
`ifndef WEIGHT_CHECKSUM_EN
            if (i == wb.size() - 1) sb.push_back(e);
`endif
            send(wb[i]);
        end
`ifdef WEIGHT_CHECKSUM_EN
        if (gap) @(negedge clk);
        commit = !bad_sum;
        if (commit) sb.push_back(e);
        send(sum ^ {7'b0, bad_sum});
`else
        commit = 1'b1;
        if (bad_sum) sum = '0;
`endif
        if (commit) begin
            check("commit_ready", W'(bus.in_ready), '0);
            @(negedge clk);
            check("done_latency", W'(uo_load_done), W'(1));
            check("err_flag", W'(uo_err), W'(ill));
        end else begin
            check("bad_sum_busy", W'(uo_busy), '0);
            @(negedge clk);
            check("bad_sum_done", W'(uo_load_done), '0);
            check("bad_sum_err", W'(uo_err), W'(1));
            check("bad_sum_keep", uo_weights, cur_img);
        end
        @(negedge clk);
    endtask

    function automatic void rand_stream(input int rows, output logic [7:0] q[$]);
        q = {};
        for (int i = 0; i < rows * 2; i++) q.push_back(legal_byte());
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] q[$];
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        repeat (3) @(negedge clk);
        check("rst_param", W'(uo_param), '0);
        check("rst_weights", uo_weights, '0);
        check("rst_done", W'(uo_load_done), '0);
        check("rst_busy", W'(uo_busy), '0);
        check("rst_err", W'(uo_err), '0);
        rst_n = 1'b1;
        ena   = 1'b1;
        @(negedge clk);
        check("rst_ready", W'(bus.in_ready), W'(1));

        q = {8'h55, 8'hFF, 8'h00, 8'h11};
        load(7'h08, q, 1'b0, 1'b0);
        check("rows_hi_zero", uo_weights[W-1:32], '0);

        rand_stream(16, q);
        load(7'h78, q, 1'b1, 1'b0);

        q = {8'h41, 8'h02};
        load(7'h00, q, 1'b0, 1'b0);

        // abort a load after three weight bytes
        send(8'h10);
        for (int i = 0; i < 3; i++) send(legal_byte());
        ena = 1'b0;
        @(negedge clk);
        check("abort_busy", W'(uo_busy), '0);
        check("abort_ready", W'(bus.in_ready), '0);
        check("abort_weights", uo_weights, cur_img);
        check("abort_param", W'(uo_param), W'(cur_param));
        ena = 1'b1;
        @(negedge clk);

`ifdef WEIGHT_CHECKSUM_EN
        rand_stream(2, q);
        load(7'h0B, q, 1'b0, 1'b0);
        load(7'h0B, q, 1'b0, 1'b1);
        check("bad_sum_param", W'(uo_param), W'(cur_param));
`endif

        for (int t = 0; t < 8; t++) begin
            int rows = $urandom_range(1, 16);
            logic [6:0] prm = {3'($urandom), 1'b0, 3'($urandom)};
            prm[6:3] = 4'(rows - 1);
            rand_stream(rows, q);
            if ($urandom_range(0, 3) == 0)
                q[$urandom_range(0, q.size() - 1)] = 8'h08;
            load(prm, q, 1'($urandom), 1'b0);
        end

        // reset in the middle of a load
        send(8'h38);
        send(legal_byte());
        send(legal_byte());
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("mid_rst_weights", uo_weights, '0);
        check("mid_rst_param", W'(uo_param), '0);
        check("mid_rst_busy", W'(uo_busy), '0);
        check("mid_rst_err", W'(uo_err), '0);
        check("mid_rst_ready", W'(bus.in_ready), W'(1));
        cur_img   = '0;
        cur_param = '0;
        @(negedge clk);

        rand_stream(3, q);
        load(7'h10, q, 1'b0, 1'b0);

        repeat (4) @(negedge clk);
        check("sb_drained", W'(sb.size()), '0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
